vector_bitwise_sequencer: RTL
=============================

// Module: vector_bitwise_sequencer
// PURPOSE
//  Issue-side sequencer feeding vector_bitwise_unit. Accepts one vector bitwise/min-max instruction,
//  splits it into LMUL register beats, reads operands from the VRF, drives the unit, applies tail-undisturbed merge.
//  Returns each beat to writeback via a valid/ready handshake. Sits between decode/issue and VRF writeback.
// PARAMETERS
//  VLEN   32             register width in bits, also the width of one beat
//  VL_W   $clog2(VLEN+1) vl width; the maximum vl is VLEN (SEW=8, LMUL=8)
// PORTS
//  clk          in   1     clock; single clock domain
//  reset        in   1     synchronous, active-high reset
//  issue_valid  in   1     instruction valid
//  issue_ready  out  1     high only in IDLE
//  issue_op     in   5     0 AND,1 OR,2 XOR,3 NOT,4 MINU,5 MIN,6 MAXU,7 MAX; 8..31 illegal
//  issue_sew    in   2     00=8,01=16,10=32,11 illegal
//  issue_lmul   in   2     beats=1<<issue_lmul (1,2,4,8)
//  issue_vl     in   VL_W  active element count
//  rd_req       out  1     VRF read strobe; data returns next cycle
//  rd_beat      out  3     beat index being read
//  rd_data_a    in   VLEN  vs2 beat
//  rd_data_b    in   VLEN  vs1 beat
//  rd_vd_old    in   VLEN  old vd beat, used for tail elements
//  dataA/dataB  out  VLEN  to vector_bitwise_unit
//  bitwise_op   out  5     to unit, held for the whole instruction
//  sew          out  2     to unit, held for the whole instruction
//  bitwise_result in VLEN  from unit
//  bitwise_done in   1     from unit; result is sampled only while it is 1
//  wb_valid     out  1     beat result valid
//  wb_ready     in   1     writeback accept
//  wb_data      out  VLEN  merged beat
//  wb_beat      out  3     beat index
//  wb_last      out  1     final beat of the instruction
//  instr_done   out  1     1-cycle pulse when the instruction retires
//  instr_error  out  1     1-cycle pulse on illegal op or sew
// BEHAVIOUR
//  Reset: FSM=IDLE; outputs 0 except issue_ready=1. Reset mid-instruction aborts it: no further wb, no done pulse.
//  FSM IDLE->READ->EXEC->WB->(READ | DONE)->IDLE.
//  IDLE: on issue_valid&&issue_ready, latch op/sew/lmul/vl, beat=0.
//    If op>7 or sew==11: next is ERR (instr_error pulse), then IDLE.
//    Else if vl==0: next is DONE; no reads, no wb.
//    Else next is READ.
//  READ: rd_req=1, rd_beat=beat, for one cycle.
//  EXEC: capture rd_data_a/b/vd_old into operand registers, which drive dataA/dataB.
//    Stay in EXEC until bitwise_done=1, then register the merged result -> WB.
//  Merge: epb=VLEN/(8<<sew). Element i of beat b takes the result if b*epb+i < vl, else vd_old.
//    Comparison is done at VL_W+3 bits; no wrap.
//  WB: wb_valid=1; wb_data/beat/last stable until wb_ready. wb_last = (beat==(1<<lmul)-1) || ((beat+1)*epb >= vl).
//    On accept: if wb_last -> DONE, else beat++ -> READ. Beats wholly past vl are not issued.
//  DONE: instr_done=1 for one cycle -> IDLE.
//  Per-beat latency without stalls: READ, EXEC, WB = 3 cycles. issue_valid is ignored outside IDLE.
// STRUCTURE
//  Package vbit_pkg: op enum (AND..MAX), sew enum, FSM state enum, function elems_per_beat(sew).
//  One sub-module vbit_tail_merge (comb: result, vd_old, sew, beat, vl -> merged beat). The FSM and registers stay here.
// TESTING (VLEN=32, unit instantiated)
//  1. AND, sew8, lmul0, vl=4, A=04030201, B=EDEEEFF0 -> one wb, 04020200, wb_last=1, then instr_done.
//  2. Same as 1 with vl=2, vd_old=AAAAAAAA -> wb_data=AAAA0200.
//  3. MAX, sew16, lmul1, vl=3, beat0 A=00650064 B=00330032 -> wb 00650064. Beat1 A=00670066 B=00350034 vd_old=FFFFFFFF -> FFFF0066, wb_last=1.
//  4. wb_ready held low 3 cycles in test 1 -> wb_data stable, rd_req=0 throughout, accepted on 4th cycle.
//  5. issue_op=9 (and separately sew=11) -> instr_error pulse, no rd_req, no wb, issue_ready high 2 cycles later.
//  6. reset asserted during EXEC of beat 1 of a lmul2 op -> next cycle IDLE, wb_valid=0, no instr_done; vl=0 issue -> instr_done only.

Source files
------------

// File: rtl/vector_bitwise_sequencer_pkg.sv
// Shared types for the vector bitwise sequencer: operation codes, element
// widths, FSM state encoding and the elements-per-beat helper.
// No ports; imported by the interface, the tail merge and the top.
package vector_bitwise_sequencer_pkg;

  typedef enum logic [4:0] {
    OP_AND  = 5'd0,
    OP_OR   = 5'd1,
    OP_XOR  = 5'd2,
    OP_NOT  = 5'd3,
    OP_MINU = 5'd4,
    OP_MIN  = 5'd5,
    OP_MAXU = 5'd6,
    OP_MAX  = 5'd7
  } op_e;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2
  } sew_e;

  localparam logic [1:0] SEW_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // Elements of width 8<<sew that fit in one vlen-bit beat.
  function automatic int unsigned elems_per_beat(input logic [1:0] s, input int unsigned vlen);
    return vlen >> (32'd3 + 32'(s));
  endfunction

endpackage

// File: rtl/vector_bitwise_sequencer_if.sv
// Bundle of every non-clock signal around the sequencer: issue port, VRF
// read port, bitwise unit port, writeback port, status pulses and a debug
// view of the FSM state.
//   master : the sequencer's view (drives rd_*, dataA/B, wb_*, status)
//   slave  : the surrounding pipeline's view (issue, VRF, unit, wb_ready)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. A source holding valid keeps its payload stable until that
// edge; ready may be driven freely and never depends on a later valid.
interface vector_bitwise_sequencer_if
  import vector_bitwise_sequencer_pkg::*;
#(
  parameter int VLEN = 32,
  parameter int VL_W = $clog2(VLEN + 1)
) ();

  logic            issue_valid;
  logic            issue_ready;
  logic [4:0]      issue_op;
  logic [1:0]      issue_sew;
  logic [1:0]      issue_lmul;
  logic [VL_W-1:0] issue_vl;

  logic            rd_req;
  logic [2:0]      rd_beat;
  logic [VLEN-1:0] rd_data_a;
  logic [VLEN-1:0] rd_data_b;
  logic [VLEN-1:0] rd_vd_old;

  logic [VLEN-1:0] dataA;
  logic [VLEN-1:0] dataB;
  logic [4:0]      bitwise_op;
  logic [1:0]      sew;
  logic [VLEN-1:0] bitwise_result;
  logic            bitwise_done;

  logic            wb_valid;
  logic            wb_ready;
  logic [VLEN-1:0] wb_data;
  logic [2:0]      wb_beat;
  logic            wb_last;

  logic            instr_done;
  logic            instr_error;
  state_e          state;

  modport master (
    input  issue_valid, issue_op, issue_sew, issue_lmul, issue_vl,
    input  rd_data_a, rd_data_b, rd_vd_old,
    input  bitwise_result, bitwise_done,
    input  wb_ready,
    output issue_ready, rd_req, rd_beat,
    output dataA, dataB, bitwise_op, sew,
    output wb_valid, wb_data, wb_beat, wb_last,
    output instr_done, instr_error, state
  );

  modport slave (
    output issue_valid, issue_op, issue_sew, issue_lmul, issue_vl,
    output rd_data_a, rd_data_b, rd_vd_old,
    output bitwise_result, bitwise_done,
    output wb_ready,
    input  issue_ready, rd_req, rd_beat,
    input  dataA, dataB, bitwise_op, sew,
    input  wb_valid, wb_data, wb_beat, wb_last,
    input  instr_done, instr_error, state
  );

endinterface

// File: rtl/vector_bitwise_sequencer_tail_merge.sv
// Tail-undisturbed merge for one beat (combinational).
//   result : unit output for this beat
//   vd_old : previous destination contents for this beat
//   sew    : element width code (0=8, 1=16, 2=32)
//   beat   : beat index inside the register group
//   vl     : active element count of the instruction
//   merged : element i takes result when beat*epb+i < vl, else vd_old
module vector_bitwise_sequencer_tail_merge
  import vector_bitwise_sequencer_pkg::*;
#(
  parameter int VLEN = 32,
  parameter int VL_W = $clog2(VLEN + 1)
) (
  input  logic [VLEN-1:0] result,
  input  logic [VLEN-1:0] vd_old,
  input  logic [1:0]      sew,
  input  logic [2:0]      beat,
  input  logic [VL_W-1:0] vl,
  output logic [VLEN-1:0] merged
);

  // Three extra bits hold beat*epb for beat up to 7 without wrapping.
  localparam int IDX_W  = VL_W + 3;
  localparam int NBYTES = VLEN / 8;

  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] vl_ext;

  assign base   = IDX_W'(beat) * IDX_W'(elems_per_beat(sew, VLEN));
  assign vl_ext = IDX_W'(vl);

  // Decide per byte: every byte of an element shares that element's index.
  for (genvar k = 0; k < NBYTES; k++) begin : g_byte
    logic [IDX_W-1:0] idx;
    assign idx = base + IDX_W'(k >> sew);
    assign merged[8*k +: 8] = (idx < vl_ext) ? result[8*k +: 8] : vd_old[8*k +: 8];
  end

endmodule

// File: rtl/vector_bitwise_sequencer.sv
// Issue-side sequencer for the vector bitwise unit. Takes one instruction,
// walks its LMUL beats (READ -> EXEC -> WB per beat), reads operands from
// the VRF, drives the unit, merges the tail and hands each beat to
// writeback.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : master view of vector_bitwise_sequencer_if (issue, VRF
//                read, unit, writeback, done/error pulses, state debug)
module vector_bitwise_sequencer
  import vector_bitwise_sequencer_pkg::*;
#(
  parameter int VLEN = 32,
  parameter int VL_W = $clog2(VLEN + 1)
) (
  input logic                        clk,
  input logic                        reset,
  vector_bitwise_sequencer_if.master bus
);

  localparam int IDX_W = VL_W + 3;

  state_e          state_q;
  logic [4:0]      op_q;
  logic [1:0]      sew_q;
  logic [1:0]      lmul_q;
  logic [VL_W-1:0] vl_q;
  logic [2:0]      beat_q;
  logic [VLEN-1:0] a_q;
  logic [VLEN-1:0] b_q;
  logic [VLEN-1:0] vd_q;
  logic            exec_first_q;

  logic            issue_ready_q;
  logic            rd_req_q;
  logic [2:0]      rd_beat_q;
  logic            wb_valid_q;
  logic [VLEN-1:0] wb_data_q;
  logic [2:0]      wb_beat_q;
  logic            wb_last_q;
  logic            done_q;
  logic            error_q;

  logic [VLEN-1:0] a_cur;
  logic [VLEN-1:0] b_cur;
  logic [VLEN-1:0] vd_cur;
  logic [VLEN-1:0] merged;
  logic [2:0]      beat_max;
  logic [IDX_W-1:0] next_base;
  logic            last_beat;

  // VRF data is only valid in the first EXEC cycle. That cycle forwards it
  // straight to the unit while it is captured, so a single-cycle unit still
  // gives a 3-cycle beat; later EXEC cycles use the captured copy.
  assign a_cur  = exec_first_q ? bus.rd_data_a : a_q;
  assign b_cur  = exec_first_q ? bus.rd_data_b : b_q;
  assign vd_cur = exec_first_q ? bus.rd_vd_old : vd_q;

  vector_bitwise_sequencer_tail_merge #(
    .VLEN (VLEN),
    .VL_W (VL_W)
  ) u_tail_merge (
    .result (bus.bitwise_result),
    .vd_old (vd_cur),
    .sew    (sew_q),
    .beat   (beat_q),
    .vl     (vl_q),
    .merged (merged)
  );

  // Last beat: end of the register group, or no active element beyond it.
  assign beat_max  = 3'((4'd1 << lmul_q) - 4'd1);
  assign next_base = (IDX_W'(beat_q) + IDX_W'(1)) * IDX_W'(elems_per_beat(sew_q, VLEN));
  assign last_beat = (beat_q == beat_max) || (next_base >= IDX_W'(vl_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      sew_q         <= '0;
      lmul_q        <= '0;
      vl_q          <= '0;
      beat_q        <= '0;
      a_q           <= '0;
      b_q           <= '0;
      vd_q          <= '0;
      exec_first_q  <= 1'b0;
      issue_ready_q <= 1'b1;
      rd_req_q      <= 1'b0;
      rd_beat_q     <= '0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_beat_q     <= '0;
      wb_last_q     <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      rd_req_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.issue_valid && issue_ready_q) begin
            op_q          <= bus.issue_op;
            sew_q         <= bus.issue_sew;
            lmul_q        <= bus.issue_lmul;
            vl_q          <= bus.issue_vl;
            beat_q        <= '0;
            issue_ready_q <= 1'b0;
            if ((bus.issue_op > OP_MAX) || (bus.issue_sew == SEW_ILLEGAL)) begin
              state_q <= ST_ERR;
              error_q <= 1'b1;
            end else if (bus.issue_vl == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_READ;
              rd_req_q  <= 1'b1;
              rd_beat_q <= '0;
            end
          end
        end
        ST_READ: begin
          state_q      <= ST_EXEC;
          exec_first_q <= 1'b1;
        end
        ST_EXEC: begin
          if (exec_first_q) begin
            a_q          <= bus.rd_data_a;
            b_q          <= bus.rd_data_b;
            vd_q         <= bus.rd_vd_old;
            exec_first_q <= 1'b0;
          end
          if (bus.bitwise_done) begin
            wb_data_q  <= merged;
            wb_beat_q  <= beat_q;
            wb_last_q  <= last_beat;
            wb_valid_q <= 1'b1;
            state_q    <= ST_WB;
          end
        end
        ST_WB: begin
          if (bus.wb_ready) begin
            wb_valid_q <= 1'b0;
            if (wb_last_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              beat_q    <= beat_q + 3'd1;
              rd_beat_q <= beat_q + 3'd1;
              rd_req_q  <= 1'b1;
              state_q   <= ST_READ;
            end
          end
        end
        ST_DONE, ST_ERR: begin
          state_q       <= ST_IDLE;
          issue_ready_q <= 1'b1;
        end
        default: begin
          state_q       <= ST_IDLE;
          issue_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.issue_ready = issue_ready_q;
  assign bus.rd_req      = rd_req_q;
  assign bus.rd_beat     = rd_beat_q;
  assign bus.dataA       = a_cur;
  assign bus.dataB       = b_cur;
  assign bus.bitwise_op  = op_q;
  assign bus.sew         = sew_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_beat     = wb_beat_q;
  assign bus.wb_last     = wb_last_q;
  assign bus.instr_done  = done_q;
  assign bus.instr_error = error_q;
  assign bus.state       = state_q;

endmodule
